// File: rtl/cla_pkg.sv
// Shared definitions for the digit-serial carry-lookahead add/subtract engine.
// Holds the slice width, the controller state encoding and sizing helpers.
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

    // Index counter width; a single-slice engine still needs a 1-bit counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Parameterised carry-lookahead adder: every carry is a flat sum of
// generate/propagate products rather than a ripple chain.
module carry_lookahead_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    // Carry into bit hi+1: OR over j of g[j] & p[j+1..hi], plus cin & p[0..hi].
    function automatic logic la_carry(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input logic             cin,
        input int               hi
    );
        logic acc;
        logic chain;
        acc   = 1'b0;
        chain = 1'b1;
        for (int j = hi; j >= 0; j--) begin
            acc   = acc | (chain & g[j]);
            chain = chain & p[j];
        end
        return acc | (chain & cin);
    endfunction

    assign gen      = a_i & b_i;
    assign prop     = a_i ^ b_i;
    assign carry[0] = cin_i;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign carry[gi+1] = la_carry(gen, prop, cin_i, gi);
        assign sum_o[gi]   = prop[gi] ^ carry[gi];
    end

    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/cla_addsub_seq.sv
// Digit-serial add/subtract engine: one 4-bit lookahead slice is reused per
// clock, with the carry held in a register between digits.
module cla_addsub_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int IDXW   = idx_width(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_width_check
        $error("cla_addsub_seq: WIDTH must be a positive multiple of 4");
    end

    addsub_state_t    state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [SLICE_W-1:0] a_dig [NSLICE];
    logic [SLICE_W-1:0] b_dig [NSLICE];
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_digit
        assign a_dig[gi] = a_q[gi*SLICE_W +: SLICE_W];
        assign b_dig[gi] = b_q[gi*SLICE_W +: SLICE_W];
    end

    assign slice_a = a_dig[idx_q];
    assign slice_b = b_dig[idx_q];

    carry_lookahead_adder #(
        .WIDTH (SLICE_W)
    ) u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // b is stored pre-inverted for subtract so the datapath only ever adds.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{op}};
                    carry_d = op;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        result_d[i*SLICE_W +: SLICE_W] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                    cout_d  = slice_cout;
                    ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[SLICE_W-1] ^ slice_cout;
                    zero_d  = ~|result_d;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: doc/cla_addsub_seq.md
# cla_addsub_seq

Multi-cycle add/subtract engine for wide operands. It processes one 4-bit digit per clock through a single 4-bit carry-lookahead slice and rippling the carry between cycles. Subtraction is the inverse operation: A − B is computed as A + ~B + 1. Operands enter through a valid/ready request port, and results leave through a valid/ready response port. The block sits between an operand source and a result consumer wherever area matters more than single-cycle latency.

## Interface
- `WIDTH`, 16, operand/result width; must be a multiple of 4 and ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  operands and op are valid.
- `req_ready`  out  1  block can accept a request (high only in IDLE).
- `a`  in  WIDTH  first operand.
- `b`  in  WIDTH  second operand.
- `op`  in  1  0 = a+b, 1 = a−b.
- `rsp_valid`  out  1  result is valid (high only in DONE).
- `rsp_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  sum/difference modulo 2^WIDTH.
- `cout`  out  1  carry out of MSB; for subtract, 1 = no borrow (a ≥ b unsigned).
- `ovf`  out  1  signed two's-complement overflow.
- `zero`  out  1  result == 0.

## Operation
- NSLICE = WIDTH/4. FSM states: IDLE, RUN, DONE.
- IDLE: `req_ready`=1. When `req_valid`=1 at an edge, latch a, b^{WIDTH{op}}, carry=op, idx=0; go to RUN.
- RUN: each cycle, slice idx adds a[4idx+:4], b'[4idx+:4] and carry.
  - Write the 4-bit sum into result[4idx+:4].
  - carry ← slice carry_out; idx ← idx+1.
  - After the slice with idx = NSLICE−1, go to DONE.
  - `req_valid` is ignored during RUN.
- DONE: `rsp_valid`=1. `result`, `cout`, `ovf`, `zero` are held stable until `rsp_ready`=1 at an edge, then go to IDLE.
- There is no same-cycle turnaround: a new request can be accepted only in the cycle after the DONE→IDLE transition.
- Flag rules:
  - `cout` = final carry.
  - `ovf` = a[W−1]^b'[W−1]^result[W−1]^cout (carry-in of MSB XOR carry-out of MSB).
  - `zero` = ~|result.
- Operand/op changes at the inputs after acceptance have no effect.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - state=IDLE, `req_ready`=1.
  - `rsp_valid`=0, `result`=0, `cout`=0, `ovf`=0, `zero`=0.
  - idx=0; internal operand registers cleared.
- Latency: request accepted at edge E; `rsp_valid` rises after edge E+NSLICE (4 cycles for WIDTH=16).
- Throughput: one result per NSLICE+2 cycles with `rsp_ready` held high.
- `ovf`/`zero`/`cout` are valid only while `rsp_valid`=1. They are registered on entry to DONE and are not combinational from `rsp_ready`.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted and outputs return to reset values immediately. After deassertion the block is in IDLE with no residual result.
- WIDTH=4: RUN lasts exactly one cycle.

## Structure
- Shared package `cla_pkg`:
  - `SLICE_W` = 4.
  - State enum `addsub_state_t` {IDLE, RUN, DONE}.
  - Function `nslice(width)`.
- One sub-module: the existing `carry_lookahead_adder` instantiated with WIDTH=4 as the per-cycle slice. No other hierarchy.
- Slice select uses an idx counter of width $clog2(NSLICE) (minimum 1).
- Elaboration-time assertion: WIDTH % 4 == 0.

## Test plan
All scenarios use WIDTH=16.
- Add 0x1234 + 0x0FFF → result 0x2233, cout=0, ovf=0, zero=0; `rsp_valid` rises exactly 4 cycles after the accept edge.
- Subtract 0x0005 − 0x0007 → 0xFFFE, cout=0 (borrow), ovf=0, zero=0.
- Subtract 0x8000 − 0x0001 → 0x7FFF, cout=1, ovf=1.
- Add 0xFFFF + 0x0001 → 0x0000, cout=1, ovf=0, zero=1.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in DONE while toggling `req_valid`, a and b.
  - Required: outputs stable, `req_ready`=0, no new accept.
  - Release `rsp_ready`: the next accept happens one cycle later.
- Reset mid-RUN: pull `rst_n` low during idx=2.
  - Required: `rsp_valid`=0 and `req_ready`=1 immediately.
  - A subsequent 0x0001+0x0001 returns 0x0002.
- Exhaustive random soak: 10k random a/b/op with random `rsp_ready` stalls, compared against {cout,result} = a + (op ? ~b+1 : b) computed in 17 bits.
